// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared types for the pipelined ARM barrel shifter (shift_pipe).
//   sh_t             : ARM shift type encoding (matches the 2-bit sh field).
//   side_t           : width-independent sideband that travels with every beat.
//   levels_per_stage : number of mux levels that share one pipeline register.
// Optional macro: SHIFT_CARRY_EN adds the carry bit to the sideband.
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_t;

  // Sideband of a beat. Data and amount widths depend on module parameters,
  // so the full stage_t (data, amt, side) is declared inside shift_pipe.
  typedef struct packed {
    sh_t  sh;
    logic rrx;
`ifdef SHIFT_CARRY_EN
    logic cin;     // running carry: C flag in, last bit shifted out
`endif
    logic ovf;     // amount >= WIDTH, detected before the first level
    logic valid;
  } side_t;

  function automatic int levels_per_stage(input int width, input int stages);
    int l;
    l = $clog2(width);
    return (l + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shift_level.sv
// -----------------------------------------------------------------------------
// shift_level
// One combinational mux level of the barrel shifter: shifts or rotates the
// operand by 2**K when i_en (amount bit K) is set, otherwise passes through.
// Ports:
//   i_data / o_data : operand in / out
//   i_sh            : shift type
//   i_en            : amount bit K
//   i_cin / o_cout  : running carry in / out (SHIFT_CARRY_EN only)
// Optional macro: SHIFT_CARRY_EN builds the carry path.
// -----------------------------------------------------------------------------
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] i_data,
  input  sh_t              i_sh,
  input  logic             i_en,
`ifdef SHIFT_CARRY_EN
  input  logic             i_cin,
  output logic             o_cout,
`endif
  output logic [WIDTH-1:0] o_data
);

  localparam int S = 1 << K;

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      case (i_sh)
        SH_LSL:  o_data = i_data << S;
        SH_LSR:  o_data = i_data >> S;
        SH_ASR:  o_data = $signed(i_data) >>> S;
        default: o_data = {i_data[S-1:0], i_data[WIDTH-1:S]};
      endcase
    end
  end

`ifdef SHIFT_CARRY_EN
  // The carry of a composed shift is the last bit shifted out, i.e. the carry
  // of the highest enabled level. For ROR, bit S-1 becomes the new MSB.
  always_comb begin
    o_cout = i_cin;
    if (i_en) begin
      o_cout = (i_sh == SH_LSL) ? i_data[WIDTH-S] : i_data[S-1];
    end
  end
`endif

endmodule

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
// Pipelined ARM operand-2 barrel shifter (LSL/LSR/ASR/ROR/RRX) with
// valid/ready on both sides. The $clog2(WIDTH) mux levels are split into
// STAGES groups, each followed by a register; latency is STAGES cycles.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   in_valid / in_ready    : input handshake
//   in_data, in_amt        : operand and shift amount (0..2**AMT_W-1)
//   in_sh, in_rrx, in_cin  : shift type, RRX select (with ROR), C flag
//   out_valid / out_ready  : output handshake
//   out_data               : shifted result
//   out_cout               : shifter carry-out (SHIFT_CARRY_EN only)
// Optional macro: SHIFT_CARRY_EN builds the carry logic and out_cout.
// -----------------------------------------------------------------------------
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int AMT_W  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_sh,
  input  logic             in_rrx,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFT_CARRY_EN
  output logic             out_cout,
`endif
  output logic [WIDTH-1:0] out_data
);

  localparam int L   = $clog2(WIDTH);
  localparam int LPS = levels_per_stage(WIDTH, STAGES);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] amt;
    side_t            side;
  } stage_t;

  stage_t            w_head;
  stage_t            w_last;
  logic [STAGES-1:0] w_vld;
  logic [STAGES-1:0] w_adv;
  logic              w_unused;

  // RRX is resolved up front: the rotated-through-carry operand enters the
  // levels with a zero amount, so later stages only pass it along.
  always_comb begin
    w_head            = '0;
    w_head.data       = in_data;
    w_head.amt        = in_amt;
    w_head.side.sh    = sh_t'(in_sh);
    w_head.side.ovf   = |(in_amt >> L);
    w_head.side.valid = in_valid;
`ifdef SHIFT_CARRY_EN
    w_head.side.cin   = in_cin;
`endif
    if (in_sh == 2'b11 && in_rrx) begin
      w_head.data     = {in_cin, in_data[WIDTH-1:1]};
      w_head.amt      = '0;
      w_head.side.rrx = 1'b1;
      w_head.side.ovf = 1'b0;
`ifdef SHIFT_CARRY_EN
      w_head.side.cin = in_data[0];
`endif
    end
  end

  // Stage s advances when it or any later stage is empty, or the consumer
  // takes the result. Computed from registered valids only (no comb chain).
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      w_adv[s] = out_ready;
      for (int j = s; j < STAGES; j++) begin
        if (!w_vld[j]) w_adv[s] = 1'b1;
      end
    end
  end

  assign in_ready = w_adv[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_grp
    localparam int LO = g * LPS;
    localparam int HI = (LO + LPS < L) ? (LO + LPS) : L;

    stage_t w_in;
    stage_t w_grp;
    stage_t w_next;
    stage_t r_q;

    if (g == 0) begin : g_src_head
      assign w_in = w_head;
    end else begin : g_src_prev
      assign w_in = g_grp[g-1].r_q;
    end

    for (genvar k = LO; k < HI; k++) begin : g_lvl
      stage_t           w_src;
      stage_t           w_dst;
      logic [WIDTH-1:0] w_shd;
`ifdef SHIFT_CARRY_EN
      logic             w_shc;
`endif

      if (k == LO) begin : g_first
        assign w_src = w_in;
      end else begin : g_chain
        assign w_src = g_lvl[k-1].w_dst;
      end

      shift_level #(
        .WIDTH (WIDTH),
        .K     (k)
      ) u_level (
        .i_data (w_src.data),
        .i_sh   (w_src.side.sh),
        .i_en   (w_src.amt[k]),
`ifdef SHIFT_CARRY_EN
        .i_cin  (w_src.side.cin),
        .o_cout (w_shc),
`endif
        .o_data (w_shd)
      );

      always_comb begin
        w_dst      = w_src;
        w_dst.data = w_shd;
`ifdef SHIFT_CARRY_EN
        w_dst.side.cin = w_shc;
`endif
      end
    end

    // Groups past the last level (STAGES not dividing L evenly) are pure
    // delay so that latency stays exactly STAGES.
    if (HI > LO) begin : g_has_lvl
      assign w_grp = g_lvl[HI-1].w_dst;
    end else begin : g_no_lvl
      assign w_grp = w_in;
    end

    if (g == STAGES - 1) begin : g_tail
`ifdef SHIFT_CARRY_EN
      logic w_eqw;
      assign w_eqw = (AMT_W > L) && (w_grp.amt == AMT_W'(WIDTH));
`endif
      // Saturation for amounts >= WIDTH. The levels only saw amt mod WIDTH,
      // which is exactly what ROR needs; ASR keeps the sign in the MSB.
      always_comb begin
        w_next = w_grp;
        if (!w_grp.side.rrx && w_grp.side.ovf) begin
          case (w_grp.side.sh)
            SH_LSL, SH_LSR: w_next.data = '0;
            SH_ASR:         w_next.data = {WIDTH{w_grp.data[WIDTH-1]}};
            default:        w_next.data = w_grp.data;
          endcase
        end
`ifdef SHIFT_CARRY_EN
        // amt == WIDTH leaves the operand unshifted, so bit 0 / MSB here is
        // the original bit that would have been shifted out last.
        if (!w_grp.side.rrx && w_grp.side.ovf) begin
          case (w_grp.side.sh)
            SH_LSL:  w_next.side.cin = w_eqw & w_grp.data[0];
            SH_LSR:  w_next.side.cin = w_eqw & w_grp.data[WIDTH-1];
            SH_ASR:  w_next.side.cin = w_grp.data[WIDTH-1];
            default: w_next.side.cin = w_grp.side.cin;
          endcase
        end
        // ROR carry is the result MSB for any non-zero amount, including
        // multiples of WIDTH where the data is unchanged.
        if (!w_grp.side.rrx && w_grp.side.sh == SH_ROR && (|w_grp.amt)) begin
          w_next.side.cin = w_grp.data[WIDTH-1];
        end
`endif
      end
      assign w_last = r_q;
    end else begin : g_mid
      assign w_next = w_grp;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_q <= '0;
      end else if (w_adv[g]) begin
        r_q <= w_next;
      end
    end

    assign w_vld[g] = r_q.side.valid;
  end

  assign out_valid = w_last.side.valid;
  assign out_data  = w_last.data;
`ifdef SHIFT_CARRY_EN
  assign out_cout  = w_last.side.cin;
`endif

  assign w_unused = ^{w_last.amt, w_last.side.sh, w_last.side.rrx, w_last.side.ovf};

endmodule
